mem_rd_streamer: RTL

Read-side engine for the MLP controller's `memory_block` scratchpad. On a `start` command it walks a contiguous address range (or a strided range, when configured) and drives `mem_raddr`. It absorbs the memory's 1-cycle registered read latency and presents the words as a valid/ready stream with a last marker, at full throughput under backpressure. Together with `memory_block` it forms the path from scratchpad to datapath.

---
 rtl/mem_rd_streamer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/mem_rd_streamer.sv
// mem_rd_streamer: read-side engine for the memory_block scratchpad.
// Walks an address range on `start`, absorbs the 1-cycle registered read
// latency through a 2-entry output FIFO, and emits a valid/ready stream with
// a last marker at one word per cycle.
// Optional feature: define MEM_RD_STREAM_STRIDE_EN to add the `stride` port
// (address increment sampled at start); otherwise the increment is 1.
module mem_rd_streamer #(
  parameter int DATAW = 32,
  parameter int DEPTH = 64,
  parameter int ADDRW = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ADDRW-1:0] base,
  input  logic [ADDRW:0]   count,
`ifdef MEM_RD_STREAM_STRIDE_EN
  input  logic [ADDRW-1:0] stride,
`endif
  output logic [ADDRW-1:0] mem_raddr,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [ADDRW:0] SPAN = (ADDRW+1)'(DEPTH);

  // Address advance modulo the memory depth (both operands are below DEPTH).
  function automatic logic [ADDRW-1:0] wrap_add(input logic [ADDRW-1:0] a,
                                                input logic [ADDRW-1:0] b);
    logic [ADDRW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= SPAN) sum = sum - SPAN;
    return sum[ADDRW-1:0];
  endfunction

  state_t           state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d;
  logic [ADDRW:0]   remaining_q, remaining_d;
  logic             inflight_q, inflight_d;
  logic             inflight_last_q, inflight_last_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic [1:0]       fifo_cnt_q, fifo_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [DATAW-1:0] fifo_data_q [2];
  logic [DATAW-1:0] fifo_data_d [2];
  logic             fifo_last_q [2];
  logic             fifo_last_d [2];
  logic [ADDRW-1:0] inc;

`ifdef MEM_RD_STREAM_STRIDE_EN
  logic [ADDRW-1:0] stride_q, stride_d;
  assign inc = stride_q;
`else
  assign inc = ADDRW'(1);
`endif

  logic       pop;
  logic       issue;
  logic [2:0] occ;

  assign out_valid = (fifo_cnt_q != 2'd0);
  assign out_data  = out_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign out_last  = out_valid & fifo_last_q[rd_ptr_q];
  assign mem_raddr = addr_q;
  assign busy      = busy_q;
  assign done      = done_q;

  assign pop   = out_valid & out_ready;
  // Credit: words held plus the word in flight, net of this cycle's pop, must leave room.
  assign occ   = {1'b0, fifo_cnt_q} + {2'b0, inflight_q};
  assign issue = (state_q == RUN) && (remaining_q != '0) && (occ < (3'd2 + {2'b0, pop}));

  // Next-state logic for the command FSM, address walker and output FIFO.
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    remaining_d     = remaining_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    fifo_data_d     = fifo_data_q;
    fifo_last_d     = fifo_last_q;
`ifdef MEM_RD_STREAM_STRIDE_EN
    stride_d        = stride_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d      = base;
          remaining_d = count;
`ifdef MEM_RD_STREAM_STRIDE_EN
          stride_d    = stride;
`endif
          state_d     = (count != '0) ? RUN : DONE;
        end
      end
      RUN:     if (issue && remaining_q == (ADDRW+1)'(1)) state_d = DRAIN;
      DRAIN:   if (pop && fifo_last_q[rd_ptr_q]) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (issue) begin
      addr_d          = wrap_add(addr_q, inc);
      remaining_d     = remaining_q - (ADDRW+1)'(1);
      inflight_d      = 1'b1;
      inflight_last_d = (remaining_q == (ADDRW+1)'(1));
    end

    // The word read last cycle is on mem_rdata now; capture it.
    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = mem_rdata;
      fifo_last_d[wr_ptr_q] = inflight_last_q;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;

    fifo_cnt_d = fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  // Control state with synchronous reset; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      rd_ptr_q        <= 1'b0;
      wr_ptr_q        <= 1'b0;
      fifo_cnt_q      <= 2'd0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      fifo_cnt_q      <= fifo_cnt_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  // Data storage; contents are only visible while the FIFO count says valid.
  always_ff @(posedge clk) begin
    fifo_data_q <= fifo_data_d;
    fifo_last_q <= fifo_last_d;
`ifdef MEM_RD_STREAM_STRIDE_EN
    stride_q    <= stride_d;
`endif
  end

endmodule
